// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the sequence stream checker.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // First-error record shape: word index and received data of the first mismatch.
  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] data;
  } err_info_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/seq_idle_timer.sv
// Idle-cycle counter: counts ticks since the last clear and flags the
// tick that completes TIMEOUT consecutive idle cycles. TIMEOUT==0 disables it.
module seq_idle_timer
  import seq_chk_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] idle;

    // Count consecutive idle ticks; any clear restarts the count.
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        idle <= '0;
      end else if (tick) begin
        idle <= idle + CW'(1);
      end
    end

    assign expire = tick && (idle == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/seq_stream_checker.sv
// Receive-side checker: verifies an incrementing word sequence from a
// programmed seed, counting mismatches and recording the first one.
module seq_stream_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LEN     = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned IDX_W   = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [7:0]       err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  chk_state_e       state;
  logic [WIDTH-1:0] expected;
  logic [IDX_W-1:0] idx;
  logic             start_ok;
  logic             sample;
  logic             mismatch;
  logic             last_word;
  logic             idle_tick;
  logic             idle_expire;

  assign start_ok  = start && (state != RUN);
  assign sample    = (state == RUN) && din_valid;
  assign idle_tick = (state == RUN) && !din_valid;
  assign mismatch  = sample && (din != expected);
  assign last_word = (idx == IDX_W'(LEN - 1));
  assign busy      = (state == RUN);

  seq_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok || sample),
    .tick  (idle_tick),
    .expire(idle_expire)
  );

  // Run FSM, compare against the self-advancing expected word, result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      expected       <= '0;
      idx            <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            expected       <= seed;
            idx            <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
          end
        end
        RUN: begin
          if (din_valid) begin
            if (mismatch) begin
              if (err_count != ERR_SAT) begin
                err_count <= err_count + 8'd1;
              end
              // err_count never returns to zero within a run, so zero marks the first miss.
              if (err_count == '0) begin
                first_err_idx  <= idx;
                first_err_data <= din;
              end
            end
            expected <= expected + WIDTH'(1);
            idx      <= idx + IDX_W'(1);
            // A valid last word takes priority over a coincident idle expiry.
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == '0);
            end
          end else if (idle_expire) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_checker.sv
// Self-checking bench for seq_stream_checker using a result scoreboard.
module tb_seq_stream_checker;

  logic       clk = 1'b0;
  logic       reset, start, din_valid;
  logic [7:0] seed, din;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count;
  logic [3:0] first_err_idx;
  logic [7:0] first_err_data;

  logic       b_start, b_valid;
  logic [7:0] b_seed, b_din;
  logic       b_busy, b_done, b_pass, b_timeout;
  logic [7:0] b_err;
  logic [9:0] b_fidx;
  logic [7:0] b_fdata;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       pass;
    logic       tmo;
    logic [7:0] errs;
    logic [9:0] fidx;
    logic [7:0] fdata;
  } res_t;

  res_t       sb[$];
  logic [7:0] stim_q[$];
  int         gap_q[$];
  int         start_at = -1;

  always #5 clk = ~clk;

  seq_stream_checker #(.WIDTH(8), .LEN(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .din_valid(din_valid), .din(din), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  seq_stream_checker #(.WIDTH(8), .LEN(300), .TIMEOUT(16)) dut_big (
    .clk(clk), .reset(reset), .start(b_start), .seed(b_seed),
    .din_valid(b_valid), .din(b_din), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timeout(b_timeout), .err_count(b_err),
    .first_err_idx(b_fidx), .first_err_data(b_fdata)
  );

  // Model the run from stim_q/gap_q, push the expected result, then drive it.
  task automatic drive_run(input logic [7:0] sd);
    res_t       r;
    logic [7:0] expv;
    int         n;
    r.pass = 1'b0; r.tmo = 1'b0; r.errs = '0; r.fidx = '0; r.fdata = '0;
    expv = sd;
    n = stim_q.size();
    for (int i = 0; i < n; i++) begin
      if (gap_q[i] >= 16) begin
        r.tmo = 1'b1;
        break;
      end
      if (stim_q[i] !== expv) begin
        if (r.errs == 8'd0) begin
          r.fidx  = 10'(i);
          r.fdata = stim_q[i];
        end
        if (r.errs != 8'd255) r.errs = r.errs + 8'd1;
      end
      expv = expv + 8'd1;
    end
    r.pass = !r.tmo && (r.errs == 8'd0);
    sb.push_back(r);

    start = 1'b1; seed = sd;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0;
      for (int g = 0; g < gap_q[i] && g < 16; g++) begin
        @(posedge clk); #1;
      end
      if (gap_q[i] >= 16) break;
      din_valid = 1'b1;
      din       = stim_q[i];
      if (i == start_at) begin
        start = 1'b1;
        seed  = 8'h55;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    din_valid = 1'b0;
  endtask

  // Wait (bounded) for the done pulse; lat counts negedges before it showed.
  task automatic wait_done(output bit seen, output int lat);
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        return;
      end
    end
  endtask

  task automatic load(input logic [7:0] first, input int gap);
    stim_q.delete();
    gap_q.delete();
    for (int i = 0; i < 8; i++) begin
      stim_q.push_back(first + 8'(i));
      gap_q.push_back(gap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; seed = '0; din_valid = 1'b0; din = '0;
    b_start = 1'b0; b_seed = '0; b_valid = 1'b0; b_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, pass, timeout, err_count, first_err_idx, first_err_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, done, pass, timeout, err_count, first_err_idx, first_err_data});
    end
    tests_run++;
    if ({b_busy, b_done, b_pass, b_timeout, b_err, b_fidx, b_fdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_big: got %h required 0",
               {b_busy, b_done, b_pass, b_timeout, b_err, b_fidx, b_fdata});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_clean();
    bit seen; int lat; res_t r;
    load(8'h00, 0);
    drive_run(8'h00);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || lat != 0) begin
      tests_failed++;
      $display("FAIL clean_done_latency: got seen=%0b lat=%0d required seen=1 lat=0", seen, lat);
    end
    tests_run++;
    if ({pass, timeout, err_count, busy} !== {r.pass, r.tmo, r.errs, 1'b0}) begin
      tests_failed++;
      $display("FAIL clean_result: got pass=%0b tmo=%0b err=%0d busy=%0b required pass=%0b tmo=%0b err=%0d busy=0",
               pass, timeout, err_count, busy, r.pass, r.tmo, r.errs);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || pass !== r.pass) begin
      tests_failed++;
      $display("FAIL clean_done_pulse: got done=%0b pass=%0b required done=0 pass=%0b", done, pass, r.pass);
    end
  endtask

  task automatic test_single_error();
    bit seen; int lat; res_t r;
    load(8'h00, 0);
    stim_q[3] = 8'h09;
    drive_run(8'h00);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || {pass, err_count, first_err_idx, first_err_data} !==
                 {r.pass, r.errs, r.fidx[3:0], r.fdata}) begin
      tests_failed++;
      $display("FAIL single_error: got seen=%0b pass=%0b err=%0d idx=%0d data=%h required pass=%0b err=%0d idx=%0d data=%h",
               seen, pass, err_count, first_err_idx, first_err_data, r.pass, r.errs, r.fidx, r.fdata);
    end
  endtask

  task automatic test_wrap();
    bit seen; int lat; res_t r;
    load(8'hFC, 0);
    drive_run(8'hFC);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || {pass, err_count, timeout} !== {r.pass, r.errs, r.tmo}) begin
      tests_failed++;
      $display("FAIL wrap: got seen=%0b pass=%0b err=%0d tmo=%0b required pass=%0b err=%0d tmo=%0b",
               seen, pass, err_count, timeout, r.pass, r.errs, r.tmo);
    end
  endtask

  task automatic test_stalls();
    bit seen; int lat; res_t r;
    load(8'h10, 3);
    drive_run(8'h10);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || lat != 0 || {pass, timeout} !== {r.pass, r.tmo}) begin
      tests_failed++;
      $display("FAIL stall_gaps: got seen=%0b lat=%0d pass=%0b tmo=%0b required lat=0 pass=%0b tmo=%0b",
               seen, lat, pass, timeout, r.pass, r.tmo);
    end
    load(8'h00, 0);
    gap_q[4] = 16;
    drive_run(8'h00);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || lat != 0 || {pass, timeout, busy} !== {r.pass, r.tmo, 1'b0}) begin
      tests_failed++;
      $display("FAIL stall_timeout: got seen=%0b lat=%0d pass=%0b tmo=%0b busy=%0b required lat=0 pass=%0b tmo=%0b busy=0",
               seen, lat, pass, timeout, busy, r.pass, r.tmo);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (timeout !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_hold: got tmo=%0b done=%0b required tmo=1 done=0", timeout, done);
    end
    @(posedge clk); #1;
    load(8'h00, 0);
    gap_q[4] = 15;
    drive_run(8'h00);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || lat != 0 || {pass, timeout} !== {r.pass, r.tmo}) begin
      tests_failed++;
      $display("FAIL stall_15: got seen=%0b lat=%0d pass=%0b tmo=%0b required lat=0 pass=%0b tmo=%0b",
               seen, lat, pass, timeout, r.pass, r.tmo);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen; int lat; res_t r; int dones;
    start = 1'b1; seed = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1; din = (i == 1) ? 8'hAA : 8'(i);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, pass, timeout, err_count, first_err_idx, first_err_data} !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset_outputs: got %h required 0",
               {busy, done, pass, timeout, err_count, first_err_idx, first_err_data});
    end
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL midrun_no_done: got %0d done pulses required 0", dones);
    end
    @(posedge clk); #1;
    load(8'h00, 0);
    drive_run(8'h00);
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || {pass, err_count} !== {r.pass, r.errs}) begin
      tests_failed++;
      $display("FAIL midrun_rerun: got seen=%0b pass=%0b err=%0d required pass=%0b err=%0d",
               seen, pass, err_count, r.pass, r.errs);
    end
  endtask

  task automatic test_start_during_run();
    bit seen; int lat; res_t r;
    load(8'h40, 0);
    start_at = 3;
    drive_run(8'h40);
    start_at = -1;
    wait_done(seen, lat);
    r = sb.pop_front();
    tests_run++;
    if (!seen || lat != 0 || {pass, err_count} !== {r.pass, r.errs}) begin
      tests_failed++;
      $display("FAIL start_in_run: got seen=%0b lat=%0d pass=%0b err=%0d required lat=0 pass=%0b err=%0d",
               seen, lat, pass, err_count, r.pass, r.errs);
    end
  endtask

  task automatic test_saturation();
    res_t r; bit seen;
    r.pass = 1'b0; r.tmo = 1'b0; r.errs = 8'd255; r.fidx = 10'd0; r.fdata = 8'h80;
    sb.push_back(r);
    b_start = 1'b1; b_seed = 8'h00;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b_valid = 1'b1;
      b_din   = 8'(i) ^ 8'h80;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (b_done === 1'b1) seen = 1'b1;
    end
    r = sb.pop_front();
    tests_run++;
    if (!seen || {b_pass, b_timeout, b_err, b_fidx, b_fdata} !== {r.pass, r.tmo, r.errs, r.fidx, r.fdata}) begin
      tests_failed++;
      $display("FAIL saturation: got seen=%0b pass=%0b tmo=%0b err=%0d idx=%0d data=%h required pass=0 tmo=0 err=%0d idx=%0d data=%h",
               seen, b_pass, b_timeout, b_err, b_fidx, b_fdata, r.errs, r.fidx, r.fdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_wrap();
    test_stalls();
    test_reset_midrun();
    test_start_during_run();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_stream_checker.md
Name: seq_stream_checker

Overview:
Receive-side checker for the 8-bit registered data stream produced by the flipflop datapath. The stimulus side drives an incrementing word sequence into the flipflop. This block sits at the output and samples qout-style data with a valid strobe. It verifies that the data forms an incrementing sequence from a programmed seed, and reports pass/fail, the error count and the first-error details, with an idle timeout.

Parameters:
WIDTH, 8, data word width in bits
LEN, 8, number of words per check run (must be ≥1)
TIMEOUT, 16, consecutive idle cycles in RUN that abort the run; 0 disables the timeout
IDX_W, $clog2(LEN)+1, width of the word index and first-error index

Ports:
clk  input  1  single system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  arms a new run; honoured only in IDLE or DONE
seed  input  WIDTH  first expected word; sampled on the accepted start
din_valid  input  1  din carries a word this cycle
din  input  WIDTH  data word under check
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run ends (normal end or timeout)
pass  output  1  valid from done onward: 1 if err_count==0 and no timeout
timeout  output  1  the run ended by idle timeout; held until next start or reset
err_count  output  8  mismatch count, saturates at 255
first_err_idx  output  IDX_W  index of the first mismatching word
first_err_data  output  WIDTH  received value of the first mismatching word

Behaviour:
- Reset: already decided, one clock `clk`, synchronous active-high `reset`. On a reset edge, state=IDLE and every output is 0. Internal expected, index and idle counters are 0. Reset mid-run discards the run: no done pulse, all results cleared the next cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on last word or timeout.
  - DONE -> RUN on start.
  - DONE holds otherwise.
- Accepted start:
  - expected<=seed; idx<=0; idle<=0.
  - err_count, first_err_*, pass and timeout are cleared.
  - busy rises the next cycle.
  - din is not checked in the start cycle.
- start while in RUN: ignored, no effect on counters.
- RUN, din_valid=1:
  - Compare din with expected.
  - On mismatch, err_count++ (saturating at 255). If this is the first mismatch of the run, capture idx into first_err_idx and din into first_err_data.
  - expected<=expected+1, modulo 2^WIDTH, so 8'hFF wraps to 8'h00.
  - idx++; idle<=0.
  - Expected always advances from its own count, never resyncs to din. A single dropped word therefore counts every subsequent word as an error.
- RUN, din_valid=0:
  - idle++.
  - If TIMEOUT≠0 and idle==TIMEOUT-1, go to DONE with timeout=1 and pass=0. A stall of exactly TIMEOUT cycles aborts the run.
- Last word: valid with idx==LEN-1 goes to DONE.
  - done pulses the cycle after that word is sampled; busy falls in the same cycle.
  - pass = (err_count after the final compare ==0).
- Timeout termination: done pulses the cycle after the final idle cycle.
- Simultaneous last valid word and would-be timeout: valid wins, so the run ends normally.
- DONE: results hold stable; din and din_valid are ignored.
- Latency: results are registered; there is no combinational path from din to any output.

Decomposition:
- Package seq_chk_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_e
  - typedef struct packed err_info_t {idx, data}
  - localparam ERR_SAT = 8'hFF
- Sub-module seq_idle_timer: idle counter with clear/tick/expire, parameterised by TIMEOUT, and tied off when TIMEOUT==0.
- The FSM and compare logic stay in seq_stream_checker.

Test Plan:
1. Clean run: seed=0, din_valid every cycle, din=0..7 -> done pulse one cycle after din=7, pass=1, err_count=0, timeout=0, busy low from done.
2. Single error: seed=0, din=0,1,2,9,4,5,6,7 -> err_count=1, first_err_idx=3, first_err_data=8'h09, pass=0.
3. Wrap-around: seed=8'hFC, din=FC,FD,FE,FF,00,01,02,03 -> pass=1, err_count=0.
4. Stalls and timeout:
   - 3-cycle valid gaps between words -> pass=1.
   - Second run: stall 16 cycles after the 4th word -> done one cycle after the 16th idle cycle, timeout=1, pass=0.
   - Third run: stall 15 cycles -> no timeout.
5. Reset mid-run: assert reset after the 4th word -> all outputs 0 the next cycle, no done pulse. A new start with seed=0 and din=0..7 then passes.
6. start asserted during RUN and err saturation:
   - start mid-run -> ignored, run completes normally.
   - LEN=300 with every word wrong -> err_count stays at 255, first_err_idx=0.
